// File: rtl/pipe_ctrl_if.sv
// Bundle of decode/status inputs and stall/flush/forwarding outputs shared
// between the pipeline datapath and its sequencing controller.
interface pipe_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1_idx;
  logic [4:0]  id_rs2_idx;
  logic [4:0]  id_rd_idx;
  logic        id_wben;
  logic        id_is_load;
  logic        ex_redirect;
  logic        ex_busy;
  logic        mem_busy;
  logic        stalln_pc;
  logic        stalln_id;
  logic        stalln_ex;
  logic        stalln_mem;
  logic        flush_id;
  logic        bubble_ex;
  logic [1:0]  fwd_rs1_ex;
  logic [1:0]  fwd_rs2_ex;
  logic        byp_rs1_id;
  logic        byp_rs2_id;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Datapath side: supplies decode/status, consumes sequencing controls.
  modport master (
    output id_valid, id_rs1_idx, id_rs2_idx, id_rd_idx, id_wben, id_is_load,
           ex_redirect, ex_busy, mem_busy,
    input  stalln_pc, stalln_id, stalln_ex, stalln_mem, flush_id, bubble_ex,
           fwd_rs1_ex, fwd_rs2_ex, byp_rs1_id, byp_rs2_id, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1_idx, id_rs2_idx, id_rd_idx, id_wben, id_is_load,
           ex_redirect, ex_busy, mem_busy,
    output stalln_pc, stalln_id, stalln_ex, stalln_mem, flush_id, bubble_ex,
           fwd_rs1_ex, fwd_rs2_ex, byp_rs1_id, byp_rs2_id, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard, forwarding and stall/flush controller for a five-stage pipeline.
// Tracks the destination registers held in EX, MEM and WB and decides each
// cycle which stages advance, which get a bubble and where operands come from.
module pipe_ctrl (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } slot_t;

  typedef enum logic [2:0] {
    RUN,
    LOAD_USE,
    REDIRECT,
    EX_WAIT,
    MEM_WAIT
  } mode_t;

  slot_t ex_slot, mem_slot, wb_slot, id_slot;
  mode_t mode;
  logic  load_use;
  logic [1:0] fwd1_next, fwd2_next;

  // A slot feeds source s only if it really writes a non-zero register.
  function automatic logic match(input logic valid, input logic [4:0] s, input slot_t slot);
    return valid && (s != 5'd0) && slot.wen && (slot.rd == s);
  endfunction

  // Youngest producer wins: ALU result in EX first, then anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic valid, input logic [4:0] s,
                                         input slot_t exs, input slot_t mems);
    if (match(valid, s, exs) && !exs.is_load)
      return 2'b01;
    else if (match(valid, s, mems))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign id_slot  = '{rd: bus.id_rd_idx,
                      wen: bus.id_wben & bus.id_valid,
                      is_load: bus.id_is_load & bus.id_valid};
  assign load_use = ex_slot.is_load &&
                    (match(bus.id_valid, bus.id_rs1_idx, ex_slot) ||
                     match(bus.id_valid, bus.id_rs2_idx, ex_slot));
  assign fwd1_next = fwd_sel(bus.id_valid, bus.id_rs1_idx, ex_slot, mem_slot);
  assign fwd2_next = fwd_sel(bus.id_valid, bus.id_rs2_idx, ex_slot, mem_slot);

  // Pick the highest-priority sequencing condition; held reset forces RUN so
  // the stall outputs drop back immediately even if busy inputs are high.
  always_comb begin
    mode = RUN;
    if (!rst_n)               mode = RUN;
    else if (bus.mem_busy)    mode = MEM_WAIT;
    else if (bus.ex_busy)     mode = EX_WAIT;
    else if (bus.ex_redirect) mode = REDIRECT;
    else if (load_use)        mode = LOAD_USE;
  end

  // Per-stage enables and strobes for the current condition, plus the
  // same-cycle regfile write bypass which ignores stalls entirely.
  always_comb begin
    bus.stalln_pc  = 1'b1;
    bus.stalln_id  = 1'b1;
    bus.stalln_ex  = 1'b1;
    bus.stalln_mem = 1'b1;
    bus.flush_id   = 1'b0;
    bus.bubble_ex  = 1'b0;
    unique case (mode)
      MEM_WAIT: begin
        bus.stalln_pc  = 1'b0;
        bus.stalln_id  = 1'b0;
        bus.stalln_ex  = 1'b0;
        bus.stalln_mem = 1'b0;
      end
      EX_WAIT: begin
        bus.stalln_pc = 1'b0;
        bus.stalln_id = 1'b0;
        bus.stalln_ex = 1'b0;
      end
      REDIRECT: begin
        bus.flush_id  = 1'b1;
        bus.bubble_ex = 1'b1;
      end
      LOAD_USE: begin
        bus.stalln_pc = 1'b0;
        bus.stalln_id = 1'b0;
        bus.bubble_ex = 1'b1;
      end
      default: ;
    endcase
    bus.byp_rs1_id = match(bus.id_valid, bus.id_rs1_idx, wb_slot);
    bus.byp_rs2_id = match(bus.id_valid, bus.id_rs2_idx, wb_slot);
  end

  // Scoreboard shifts in step with the real pipeline registers; forwarding
  // selects follow the instruction that EX takes from ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot        <= '0;
      mem_slot       <= '0;
      wb_slot        <= '0;
      bus.fwd_rs1_ex <= 2'b00;
      bus.fwd_rs2_ex <= 2'b00;
    end else begin
      unique case (mode)
        MEM_WAIT: begin
          wb_slot <= '0;
        end
        EX_WAIT: begin
          mem_slot <= '0;
          wb_slot  <= mem_slot;
        end
        REDIRECT, LOAD_USE: begin
          ex_slot        <= '0;
          mem_slot       <= ex_slot;
          wb_slot        <= mem_slot;
          bus.fwd_rs1_ex <= 2'b00;
          bus.fwd_rs2_ex <= 2'b00;
        end
        default: begin
          ex_slot        <= id_slot;
          mem_slot       <= ex_slot;
          wb_slot        <= mem_slot;
          bus.fwd_rs1_ex <= fwd1_next;
          bus.fwd_rs2_ex <= fwd2_next;
        end
      endcase
    end
  end

  // Performance counters for front-end stall cycles and ID flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stall_cnt <= 32'd0;
      bus.flush_cnt <= 32'd0;
    end else begin
      if (!bus.stalln_pc) bus.stall_cnt <= bus.stall_cnt + 32'd1;
      if (bus.flush_id)   bus.flush_cnt <= bus.flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic, all
// checked against a pipeline-level model of instructions moving EX->MEM->WB.
module tb_pipe_ctrl;

  logic clk;
  logic rst_n;
  pipe_ctrl_if bus();

  pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [4:0] rd;
    logic       wen;
    logic       ld;
  } instr_t;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t      pipe [3];
  logic [1:0]  m_f1, m_f2;
  logic [31:0] m_stall, m_flush;

  localparam int M_MEM = 0, M_EXB = 1, M_RED = 2, M_LU = 3, M_RUN = 4;

  function automatic bit hit(input logic [4:0] r, input instr_t p);
    return bus.id_valid && r != 0 && p.wen && p.rd != 0 && p.rd == r;
  endfunction

  function automatic int cur_mode();
    if (!rst_n) return M_RUN;
    if (bus.mem_busy) return M_MEM;
    if (bus.ex_busy) return M_EXB;
    if (bus.ex_redirect) return M_RED;
    if (pipe[0].ld && (hit(bus.id_rs1_idx, pipe[0]) || hit(bus.id_rs2_idx, pipe[0]))) return M_LU;
    return M_RUN;
  endfunction

  // {stalln_pc, stalln_id, stalln_ex, stalln_mem, flush_id, bubble_ex, byp1, byp2}
  function automatic logic [7:0] exp_ctrl();
    logic [5:0] c;
    case (cur_mode())
      M_MEM:   c = 6'b0000_00;
      M_EXB:   c = 6'b0001_00;
      M_RED:   c = 6'b1111_11;
      M_LU:    c = 6'b0011_01;
      default: c = 6'b1111_00;
    endcase
    return {c, hit(bus.id_rs1_idx, pipe[2]), hit(bus.id_rs2_idx, pipe[2])};
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (hit(r, pipe[0]) && !pipe[0].ld) return 2'b01;
    if (hit(r, pipe[1])) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] got_ctrl();
    return {bus.stalln_pc, bus.stalln_id, bus.stalln_ex, bus.stalln_mem,
            bus.flush_id, bus.bubble_ex, bus.byp_rs1_id, bus.byp_rs2_id};
  endfunction

  function automatic logic [3:0] got_fwd();
    return {bus.fwd_rs1_ex, bus.fwd_rs2_ex};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_f1 = 2'b00; m_f2 = 2'b00; m_stall = 0; m_flush = 0;
  endtask

  // Advance the model one clock: the stall point decides where a bubble is
  // inserted; stages younger than it hold, older ones move on.
  task automatic model_edge();
    int m, b;
    logic [7:0] c;
    logic [1:0] f1, f2;
    instr_t idi;
    m  = cur_mode();
    c  = exp_ctrl();
    f1 = exp_fwd(bus.id_rs1_idx);
    f2 = exp_fwd(bus.id_rs2_idx);
    idi = '{rd: bus.id_rd_idx, wen: bus.id_wben & bus.id_valid, ld: bus.id_is_load & bus.id_valid};
    if (!c[7]) m_stall++;
    if (c[3])  m_flush++;
    case (m)
      M_MEM:        b = 2;
      M_EXB:        b = 1;
      M_RED, M_LU:  b = 0;
      default:      b = -1;
    endcase
    for (int k = 2; k >= 0; k--) begin
      if (k > b) pipe[k] = (k == 0) ? idi : pipe[k-1];
      else if (k == b) pipe[k] = '0;
    end
    if (m == M_RUN) begin m_f1 = f1; m_f2 = f2; end
    else if (m == M_RED || m == M_LU) begin m_f1 = 2'b00; m_f2 = 2'b00; end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic red, input logic exb, input logic memb);
    bus.id_valid = v; bus.id_rs1_idx = rs1; bus.id_rs2_idx = rs2; bus.id_rd_idx = rd;
    bus.id_wben = wen; bus.id_is_load = ld;
    bus.ex_redirect = red; bus.ex_busy = exb; bus.mem_busy = memb;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
  endtask

  task automatic test_reset();
    checks++; if (got_ctrl() !== 8'b1111_0000) begin fails++; $display("[TB] FAIL reset_ctrl: got %b expected %b", got_ctrl(), 8'b1111_0000); end
    checks++; if ({got_fwd(), bus.stall_cnt, bus.flush_cnt} !== 68'd0) begin fails++; $display("[TB] FAIL reset_regs: got fwd %b stall %0d flush %0d expected zeros", got_fwd(), bus.stall_cnt, bus.flush_cnt); end
    // lw x5 ; add x6,x5,x1 (one stall) ; lw x9 ; add x8,x9,x9 then reset mid-stall
    drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
    drive(1, 5, 1, 6, 1, 0, 0, 0, 0); tick();
    tick();
    drive(1, 0, 0, 9, 1, 1, 0, 0, 0); tick();
    drive(1, 9, 9, 8, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== exp_ctrl() || bus.stall_cnt !== 32'd1) begin fails++; $display("[TB] FAIL reset_pre: got ctrl %b stall %0d expected %b stall 1", got_ctrl(), bus.stall_cnt, exp_ctrl()); end
    rst_n = 1'b0; #1;
    model_reset();
    checks++; if (got_ctrl() !== 8'b1111_0000) begin fails++; $display("[TB] FAIL reset_mid_ctrl: got %b expected %b", got_ctrl(), 8'b1111_0000); end
    checks++; if ({got_fwd(), bus.stall_cnt, bus.flush_cnt} !== 68'd0) begin fails++; $display("[TB] FAIL reset_mid_regs: got fwd %b stall %0d flush %0d expected zeros", got_fwd(), bus.stall_cnt, bus.flush_cnt); end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
    drive(1, 5, 1, 6, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== 8'b0011_0100) begin fails++; $display("[TB] FAIL lu_stall: got %b expected %b", got_ctrl(), 8'b0011_0100); end
    checks++; if (got_ctrl() !== exp_ctrl()) begin fails++; $display("[TB] FAIL lu_stall_model: got %b expected %b", got_ctrl(), exp_ctrl()); end
    tick();
    checks++; if (got_ctrl() !== 8'b1111_0000 || bus.stall_cnt !== 32'd1) begin fails++; $display("[TB] FAIL lu_release: got ctrl %b stall %0d expected 11110000 stall 1", got_ctrl(), bus.stall_cnt); end
    tick();
    checks++; if (got_fwd() !== 4'b1000) begin fails++; $display("[TB] FAIL lu_fwd: got %b expected %b", got_fwd(), 4'b1000); end
    checks++; if (bus.stall_cnt !== m_stall) begin fails++; $display("[TB] FAIL lu_cnt: got %0d expected %0d", bus.stall_cnt, m_stall); end
    drain();
  endtask

  task automatic test_alu_chain();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 3, 3, 4, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_0000) begin fails++; $display("[TB] FAIL alu_nostall: got %b expected %b", got_ctrl(), 8'b1111_0000); end
    tick();
    checks++; if (got_fwd() !== 4'b0101) begin fails++; $display("[TB] FAIL alu_fwd_ex: got %b expected %b", got_fwd(), 4'b0101); end
    drain();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 8, 1, 0, 0, 0, 0); tick();
    drive(1, 3, 3, 4, 1, 0, 0, 0, 0); tick();
    checks++; if (got_fwd() !== 4'b1010) begin fails++; $display("[TB] FAIL alu_fwd_mem: got %b expected %b", got_fwd(), 4'b1010); end
    drain();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0); tick();
    checks++; if (got_fwd() !== 4'b0000) begin fails++; $display("[TB] FAIL alu_fwd_x0: got %b expected %b", got_fwd(), 4'b0000); end
    drain();
  endtask

  task automatic test_wb_bypass();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0); tick();
    idle(); tick(); idle(); tick();
    drive(1, 7, 2, 9, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_0010) begin fails++; $display("[TB] FAIL byp_on: got %b expected %b", got_ctrl(), 8'b1111_0010); end
    drain();
    drive(1, 0, 0, 7, 0, 0, 0, 0, 0); tick();
    idle(); tick(); idle(); tick();
    drive(1, 7, 7, 9, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_0000) begin fails++; $display("[TB] FAIL byp_off: got %b expected %b", got_ctrl(), 8'b1111_0000); end
    drain();
  endtask

  task automatic test_redirect();
    drive(1, 1, 2, 3, 1, 0, 1, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_1100) begin fails++; $display("[TB] FAIL red_ctrl: got %b expected %b", got_ctrl(), 8'b1111_1100); end
    tick();
    idle();
    checks++; if (bus.flush_cnt !== 32'd1 || got_fwd() !== 4'b0000) begin fails++; $display("[TB] FAIL red_cnt: got flush %0d fwd %b expected 1 0000", bus.flush_cnt, got_fwd()); end
    drain();
    drive(1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
    drive(1, 5, 0, 6, 1, 0, 1, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_1100) begin fails++; $display("[TB] FAIL red_over_lu: got %b expected %b", got_ctrl(), 8'b1111_1100); end
    tick();
    idle();
    checks++; if (bus.flush_cnt !== m_flush || bus.stall_cnt !== m_stall) begin fails++; $display("[TB] FAIL red_cnt2: got flush %0d stall %0d expected %0d %0d", bus.flush_cnt, bus.stall_cnt, m_flush, m_stall); end
    drain();
  endtask

  task automatic test_busy();
    drive(1, 0, 0, 10, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 10, 0, 11, 1, 0, 0, 1, 0);
      checks++; if (got_ctrl() !== 8'b0001_0000) begin fails++; $display("[TB] FAIL exbusy_%0d: got %b expected %b", i, got_ctrl(), 8'b0001_0000); end
      tick();
    end
    drive(1, 10, 0, 11, 1, 0, 0, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_0000) begin fails++; $display("[TB] FAIL exbusy_end: got %b expected %b", got_ctrl(), 8'b1111_0000); end
    tick();
    checks++; if (got_fwd() !== 4'b0100 || bus.stall_cnt !== m_stall) begin fails++; $display("[TB] FAIL exbusy_fwd: got fwd %b stall %0d expected 0100 %0d", got_fwd(), bus.stall_cnt, m_stall); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
      checks++; if (got_ctrl() !== 8'b0000_0000) begin fails++; $display("[TB] FAIL membusy_%0d: got %b expected %b", i, got_ctrl(), 8'b0000_0000); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checks++; if (got_ctrl() !== 8'b1111_1100) begin fails++; $display("[TB] FAIL membusy_red: got %b expected %b", got_ctrl(), 8'b1111_1100); end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      checks++; if (got_ctrl() !== exp_ctrl()) begin fails++; $display("[TB] FAIL rnd_ctrl@%0d: got %b expected %b", i, got_ctrl(), exp_ctrl()); end
      checks++; if (got_fwd() !== {m_f1, m_f2}) begin fails++; $display("[TB] FAIL rnd_fwd@%0d: got %b expected %b", i, got_fwd(), {m_f1, m_f2}); end
      checks++; if (bus.stall_cnt !== m_stall || bus.flush_cnt !== m_flush) begin fails++; $display("[TB] FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] starting pipe_ctrl tests");
    test_reset();
    test_load_use();
    test_alu_chain();
    test_wb_bypass();
    test_redirect();
    test_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard, forwarding and stall/flush controller for the five-stage integer pipeline (IF/ID/EX/MEM/WB). It takes decode information from ID and status from EX/MEM, keeps a private scoreboard of destination registers in EX, MEM and WB, and drives the per-stage active-low stall enables, bubble/flush strobes and operand-forwarding selects. It is the single owner of pipeline sequencing.

## Interface
- No parameters; register index width fixed at 5.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1_idx, id_rs2_idx  in  5 each  source indices from decoder (0 when unused)
- id_rd_idx  in  5  destination index (instr[11:7])
- id_wben  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/jal/jalr; held asserted while EX is frozen
- ex_busy  in  1  multi-cycle EX operation in progress
- mem_busy  in  1  LSU waiting on memory
- stalln_pc, stalln_id, stalln_ex, stalln_mem  out  1 each  0 = stage register holds
- flush_id  out  1  ID register loads NOP at next edge
- bubble_ex  out  1  EX register loads NOP instead of ID contents
- fwd_rs1_ex, fwd_rs2_ex  out  2 each  registered, for instruction in EX: 00 latched operand, 01 MEM-stage result, 10 WB data
- byp_rs1_id, byp_rs2_id  out  1 each  combinational: ID operand takes WB write data (same-cycle regfile write)
- stall_cnt, flush_cnt  out  32 each  performance counters

## Operation
- Scoreboard slots EX/MEM/WB: {rd[4:0], wen, is_load}. A slot is a producer only if wen=1 and rd!=0.
- Match(s, slot) = id_valid & producer(slot) & slot.rd == s, for s in {rs1, rs2}; rs==0 never matches.
- Priority, highest first:
  - MEM_WAIT (mem_busy=1): all four stalln=0; flush_id=bubble_ex=0; WB slot cleared at edge; EX/MEM slots hold.
  - EX_WAIT (ex_busy=1): stalln_pc/id/ex=0, stalln_mem=1; MEM slot cleared (bubble into MEM); WB slot <= MEM slot.
  - REDIRECT (ex_redirect=1): flush_id=1, bubble_ex=1, all stalln=1; EX slot cleared; load-use ignored.
  - LOAD_USE (Match(rs1|rs2, EX) with EX.is_load): stalln_pc=stalln_id=0, bubble_ex=1; EX slot cleared; MEM/WB advance.
  - RUN: all stalln=1; EX<=ID info (wen gated by id_valid), MEM<=EX, WB<=MEM.
- Forwarding, computed on ID contents, registered into fwd_*_ex when EX loads from ID: Match with EX slot (non-load) -> 01; else Match with MEM slot -> 10; else 00. Youngest producer wins. A load in MEM matching ID yields 10.
- fwd_*_ex hold when stalln_ex=0; cleared to 00 when bubble_ex=1.
- byp_*_id = Match(s, WB slot); purely combinational, independent of stalls.
- stall_cnt +1 every cycle stalln_pc=0; flush_cnt +1 every cycle flush_id=1; both wrap at 2^32.

## Timing
- Reset (async assert, sync-safe deassert): stalln_*=1, flush_id=0, bubble_ex=0, fwd_*=00, scoreboard wen=0, counters 0, state RUN.
- stalln_*, flush_id, bubble_ex, byp_*: combinational from inputs and scoreboard, same cycle.
- Load-use costs exactly one bubble; the consumer enters EX next cycle with fwd=10.
- Redirect costs two wrong-path slots (ID flushed, EX bubbled); a redirect held through mem_busy/ex_busy takes effect the first free cycle.
- Reset mid-stall: all outputs return to reset values immediately; no residual bubble.

## Test plan
- Reset: rst_n=0 mid-load-use -> all stalln=1, fwd=00, counters 0 without a clock edge.
- Load-use: EX=load x5, ID `add x6,x5,x1` -> one cycle stalln_pc=stalln_id=0, bubble_ex=1; next cycle fwd_rs1_ex=10; stall_cnt=1.
- ALU chain: `addi x3` then `add x4,x3,x3` -> no stall, fwd_rs1_ex=fwd_rs2_ex=01; producer two ahead -> 10; rd=x0 -> 00.
- WB bypass: WB slot rd=x7 wen=1, ID reads x7 -> byp_rs1_id=1 same cycle; WB wen=0 -> 0.
- Redirect: ex_redirect=1 one cycle -> flush_id=bubble_ex=1, stalln all 1, flush_cnt=1; with simultaneous load-use, redirect wins.
- Busy: ex_busy 3 cycles -> pc/id/ex held 3 cycles, 3 MEM bubbles; mem_busy with ex_redirect held -> full freeze, flush_id deferred until mem_busy=0.
